// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider (signed/unsigned quotient and remainder).
// Optional `DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed overflow skip the iterations.
package div_pkg;
  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;
endpackage

module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  div_ops_e        ops_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  div_ops_e        op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    valid_d   = valid_q;
    signed_op = (ops_i == DIV_) || (ops_i == REM_);
    a_neg     = signed_op & dividend_i[XLEN-1];
    b_neg     = signed_op & divisor_i[XLEN-1];
    a_abs     = a_neg ? -dividend_i : dividend_i;
    b_abs     = b_neg ? -divisor_i : divisor_i;
    shifted   = {rem_q, quo_q[XLEN-1]};
    ge        = shifted >= {1'b0, dvs_q};

    if (clk_en_i) begin
      valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_d    = ops_i;
            dvs_d   = b_abs;
            quo_d   = a_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = (a_neg ^ b_neg) && (divisor_i != '0);
            rneg_d  = a_neg;
            state_d = DIVIDE;
`ifdef DIV_SPECIAL_BYPASS_EN
            // Preload the unsigned core results the iterations would produce,
            // so the common FINISH fix-up yields the special-case answers.
            if (divisor_i == '0) begin
              quo_d   = '1;
              rem_d   = a_abs;
              state_d = FINISH;
            end else if (signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (divisor_i == '1)) begin
              quo_d   = a_abs;
              rem_d   = '0;
              state_d = FINISH;
            end
`endif
          end
        end
        DIVIDE: begin
          rem_d = ge ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = FINISH;
        end
        FINISH: begin
          if ((op_q == REM_) || (op_q == REMU_))
            result_d = rneg_q ? -rem_q : rem_q;
          else
            result_d = qneg_q ? -quo_q : quo_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= DIV_;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and arrival cycle,
// a negedge monitor pops and compares on every valid_o.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clk_en_i = 1'b1;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  div_ops_e    ops_i = DIV_;
  logic        valid_i = 1'b0;
  logic [31:0] result_o;
  logic        valid_o;
  logic        busy_o;

  div_unit #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .clk_en_i  (clk_en_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .ops_i     (ops_i),
    .valid_i   (valid_i),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_valid: result_o=%h at cycle %0d, none expected", result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result_o !== e.res) begin
          failures++;
          $display("FAIL %s result: got %h expected %h", e.name, result_o, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL %s latency: valid_o at cycle %0d expected %0d", e.name, cyc, e.cyc);
        end
        last_res = e.res;
      end
    end
  end

  function automatic int lat(div_ops_e op, logic [31:0] a, logic [31:0] b);
`ifdef DIV_SPECIAL_BYPASS_EN
    if (b == 32'h0) return 1;
    if ((op == DIV_ || op == REM_) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 33;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Drive one request at a negedge; accepted on the next posedge (returned in acc).
  task automatic issue(string name, div_ops_e op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] expv, int extra, bit push, output int acc);
    exp_t e;
    @(negedge clk);
    ops_i = op; dividend_i = a; divisor_i = b; valid_i = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    valid_i = 1'b0;
    if (push) begin
      e.res = expv; e.cyc = acc + lat(op, a, b) + extra; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results never arrived (next %s)", sb.size(), sb[0].name);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check("result_hold", result_o, last_res);
  endtask

  typedef struct {
    string       name;
    div_ops_e    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];
  int   acc;

  initial begin
    vecs = '{
      '{"divu_100_7",   DIVU_, 32'd100,        32'd7,          32'h0000_000E},
      '{"div_m100_7",   DIV_,  -32'sd100,      32'd7,          32'hFFFF_FFF2},
      '{"rem_m100_7",   REM_,  -32'sd100,      32'd7,          32'hFFFF_FFFE},
      '{"remu_max_16",  REMU_, 32'hFFFF_FFFF,  32'd16,         32'h0000_000F},
      '{"div_m7_2",     DIV_,  -32'sd7,        32'd2,          32'hFFFF_FFFD},
      '{"rem_7_m2",     REM_,  32'd7,          -32'sd2,        32'h0000_0001},
      '{"div_7_m2",     DIV_,  32'd7,          -32'sd2,        32'hFFFF_FFFD},
      '{"div_by0",      DIV_,  32'h1234_5678,  32'h0,          32'hFFFF_FFFF},
      '{"rem_by0",      REM_,  32'h1234_5678,  32'h0,          32'h1234_5678},
      '{"rem_neg_by0",  REM_,  -32'sd5,        32'h0,          32'hFFFF_FFFB},
      '{"divu_by0",     DIVU_, 32'd5,          32'h0,          32'hFFFF_FFFF},
      '{"remu_by0",     REMU_, 32'd5,          32'h0,          32'h0000_0005},
      '{"div_ovf",      DIV_,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
      '{"rem_ovf",      REM_,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000},
      '{"divu_min_max", DIVU_, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000}
    };

    repeat (2) @(negedge clk);
    check("reset_result", result_o, 32'h0);
    check("reset_valid", {31'b0, valid_o}, 32'h0);
    check("reset_busy", {31'b0, busy_o}, 32'h0);
    rst_i = 1'b0;

    foreach (vecs[k]) begin
      issue(vecs[k].name, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].res, 0, 1'b1, acc);
      wait_done();
    end

    // Request held across FINISH is ignored there and taken in the next IDLE cycle.
    issue("divu_100_7_b", DIVU_, 32'd100, 32'd7, 32'd14, 0, 1'b1, acc);
    while (cyc < acc + 32) @(negedge clk);
    check("busy_finish", {31'b0, busy_o}, 32'h1);
    ops_i = DIVU_; dividend_i = 32'd9; divisor_i = 32'd3; valid_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    begin
      exp_t e;
      e.res = 32'd3; e.cyc = acc + 34 + 33; e.name = "divu_9_3_after_finish";
      sb.push_back(e);
    end
    wait_done();

    // Stall for 5 cycles mid-divide, then a request while busy that must be dropped.
    issue("divu_1000_10_stall", DIVU_, 32'd1000, 32'd10, 32'd100, 5, 1'b1, acc);
    repeat (10) @(negedge clk);
    clk_en_i = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_stalled", {31'b0, busy_o}, 32'h1);
    clk_en_i = 1'b1;
    @(negedge clk);
    ops_i = DIVU_; dividend_i = 32'd7; divisor_i = 32'd7; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    wait_done();

    // Reset at step 10 abandons the operation without a result strobe.
    issue("divu_50_5_abandon", DIVU_, 32'd50, 32'd5, 32'd10, 0, 1'b0, acc);
    while (cyc < acc + 10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_mid_busy", {31'b0, busy_o}, 32'h0);
    check("rst_mid_result", result_o, 32'h0);
    check("rst_mid_valid", {31'b0, valid_o}, 32'h0);
    last_res = '0;
    repeat (40) @(negedge clk);
    issue("divu_9_3", DIVU_, 32'd9, 32'd3, 32'd3, 0, 1'b1, acc);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port clk_en_i  input  1  clock enable; pipeline stall when low.
REQ-005 SHALL have port dividend_i  input  XLEN  dividend, as data_u.
REQ-006 SHALL have port divisor_i  input  XLEN  divisor, as data_u.
REQ-007 SHALL have port ops_i  input  div_ops_e  operation: DIV_, DIVU_, REM_ or REMU_.
REQ-008 SHALL have port valid_i  input  1  start request.
REQ-009 SHALL have port result_o  output  XLEN  quotient or remainder, selected by the latched op.
REQ-010 SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-011 SHALL have port busy_o  output  1  high while an operation is in flight.

Function
REQ-012 SHALL implement an FSM with states IDLE, DIVIDE and FINISH.
REQ-013 SHALL accept an operation only in IDLE, on an edge where valid_i=1 and clk_en_i=1.
REQ-014 SHALL, on acceptance, latch the operands and the op and enter DIVIDE.
REQ-015 SHALL, for DIV_ and REM_, divide absolute values; for DIVU_ and REMU_, use the raw unsigned operands.
REQ-016 SHALL, in DIVIDE, run one restoring radix-2 step per enabled edge, XLEN steps in total, driven by a step counter.
REQ-017 SHALL enter FINISH after the last step.
REQ-018 SHALL, in FINISH, apply sign fix-up:
- quotient is negated if the operand signs differ and the divisor is nonzero;
- remainder takes the sign of the dividend.
REQ-019 SHALL register result_o, assert valid_o for exactly one enabled cycle in FINISH, then return to IDLE.
REQ-020 SHALL, for an iterated operation, assert valid_o XLEN+1 enabled edges after the accepting edge.
REQ-021 SHALL, on divide by zero, return quotient all-ones and remainder = dividend, for both signed and unsigned ops.
REQ-022 SHALL, for signed overflow (-2^(XLEN-1) / -1), return quotient -2^(XLEN-1) and remainder 0.
REQ-023 SHALL hold result_o stable after FINISH until the next completion.
REQ-024 SHALL assert busy_o in DIVIDE and FINISH, and deassert it in IDLE.
REQ-025 SHALL ignore valid_i while busy_o=1; no queuing.
REQ-026 SHALL, when clk_en_i=0, freeze the state, counter, partial remainder, quotient and outputs, including a pending valid_o.
REQ-027 SHALL, when FINISH and valid_i=1 coincide, ignore the request; a new request is accepted from the following IDLE cycle.

Reset
REQ-028 SHALL, when rst_i=1 on a clock edge, enter IDLE regardless of clk_en_i.
REQ-029 SHALL, on reset, clear result_o to 0, valid_o to 0, busy_o to 0, the step counter and the internal registers.
REQ-030 SHALL, on reset mid-operation, abandon the operation with no valid_o pulse.
REQ-031 SHALL give reset priority over valid_i on the same edge.

Configuration
REQ-032 SHALL, when DIV_SPECIAL_BYPASS_EN is defined, detect divide by zero and signed overflow at acceptance and go IDLE->FINISH directly, with valid_o 1 enabled edge after acceptance and results per REQ-021/REQ-022.
REQ-033 SHALL, when DIV_SPECIAL_BYPASS_EN is undefined, send all operations through the full XLEN iterations, with identical results and latency per REQ-020.

Verification
REQ-034 SHALL cover: DIVU_ 100/7 -> result 14 (0x0000000E), valid_o at edge 33 after acceptance.
REQ-035 SHALL cover: DIV_ -100/7 -> 0xFFFFFFF2; REM_ -100/7 -> 0xFFFFFFFE; REMU_ 0xFFFFFFFF/16 -> 0x0000000F.
REQ-036 SHALL cover: DIV_ 0x12345678/0 -> 0xFFFFFFFF; REM_ 0x12345678/0 -> 0x12345678; latency 1 edge with the macro, 33 without.
REQ-037 SHALL cover: DIV_ 0x80000000/0xFFFFFFFF -> 0x80000000; REM_ with the same operands -> 0x00000000.
REQ-038 SHALL cover: DIVU_ 1000/10 with clk_en_i low for 5 cycles mid-DIVIDE -> result 100, valid_o delayed by exactly 5 cycles; a valid_i pulse while busy is ignored.
REQ-039 SHALL cover: rst_i pulsed at step 10 of DIVU_ 50/5 -> no valid_o, busy_o=0 and result_o=0 next cycle; a following DIVU_ 9/3 -> 3.
